rv_lsu: RTL

RV_LSU -- requirements
Module: rv_lsu

---
 rtl/rv_lsu.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rv_lsu.sv
// rv_lsu: RV32 load/store unit, one data-memory access at a time, with store lane steering and load extension.
// Build option LSU_MISALIGN_EXC_EN adds misalign_o and completes misaligned half/word accesses without a memory request.
module rv_lsu (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  output logic [3:0]  dm_be_o,
  input  logic        dm_ack_i,
  input  logic [31:0] dm_rdata_i
`ifdef LSU_MISALIGN_EXC_EN
  ,
  output logic        misalign_o
`endif
);

  // state | meaning
  // IDLE  | waiting for mem_read_i / mem_write_i; stall raised in the detect cycle
  // REQ   | dm_req_o held with stable address/data until dm_ack_i
  // DONE  | one unstalled cycle; load result (or misalign flag) visible
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;

  state_t      state;
  size_t       size_in, size_q;
  logic        uns_q, we_q;
  logic [1:0]  off_q;
  logic        access_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  assign access_in = mem_read_i | mem_write_i;

  // Stall is gated by rstn so a request held during reset cannot raise it.
  assign stall_o = rstn & (((state == IDLE) & access_in) | (state == REQ));

  always_comb begin
    case (funct3_i)
      3'b000, 3'b100: size_in = SZ_B;
      3'b001, 3'b101: size_in = SZ_H;
      default:        size_in = SZ_W;
    endcase
  end

  always_comb begin
    be_in    = 4'hF;
    wdata_in = wdata_i;
    if (mem_write_i) begin
      case (size_in)
        SZ_B: begin
          be_in    = 4'b0001 << addr_i[1:0];
          wdata_in = {4{wdata_i[7:0]}};
        end
        SZ_H: begin
          be_in    = 4'b0011 << {addr_i[1], 1'b0};
          wdata_in = {2{wdata_i[15:0]}};
        end
        default: begin
          be_in    = 4'hF;
          wdata_in = wdata_i;
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_EXC_EN
  logic misal_in;
  assign misal_in = ((size_in == SZ_H) & addr_i[0]) |
                    ((size_in == SZ_W) & (addr_i[1:0] != 2'b00));
`endif

  always_comb begin
    byte_sel = dm_rdata_i[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];
    case (size_q)
      SZ_B:    load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      SZ_H:    load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_val = dm_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      size_q     <= SZ_W;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      off_q      <= 2'b00;
      rdata_o    <= 32'h0;
      dm_req_o   <= 1'b0;
      dm_we_o    <= 1'b0;
      dm_addr_o  <= 32'h0;
      dm_wdata_o <= 32'h0;
      dm_be_o    <= 4'h0;
`ifdef LSU_MISALIGN_EXC_EN
      misalign_o <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access_in) begin
            size_q <= size_in;
            uns_q  <= funct3_i[2];
            we_q   <= mem_write_i;
            off_q  <= addr_i[1:0];
`ifdef LSU_MISALIGN_EXC_EN
            if (misal_in) begin
              state      <= DONE;
              misalign_o <= 1'b1;
            end else
`endif
            begin
              state      <= REQ;
              dm_req_o   <= 1'b1;
              dm_we_o    <= mem_write_i;
              dm_addr_o  <= {addr_i[31:2], 2'b00};
              dm_be_o    <= be_in;
              dm_wdata_o <= wdata_in;
            end
          end
        end
        REQ: begin
          if (dm_ack_i) begin
            state    <= DONE;
            dm_req_o <= 1'b0;
            dm_we_o  <= 1'b0;
            if (!we_q) rdata_o <= load_val;
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef LSU_MISALIGN_EXC_EN
          misalign_o <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
